// File: rtl/camac_cycle_sequencer.sv
// CAMAC cycle sequencer: turns 8-bit ISA register accesses into single
// 16-bit CAMAC read/write cycles. While a cycle runs, isa_chrdy is held low.
// When no cycle is in progress the data bus is left passive.
module camac_cycle_sequencer #(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [2:0]  reg_sel,
    input  logic [7:0]  wr_byte,
    output logic [7:0]  rd_byte,
    output logic        isa_chrdy,
    output logic        busy,
    output logic [11:0] cb_addr,
    output logic [15:0] cb_data_out,
    input  logic [15:0] cb_data_in,
    output logic        cb_b_b1,
    output logic        cb_cx1,
    input  logic        cb_prr
);

    // One counter serves both the setup phase and the strobe phase, so it
    // must be wide enough for whichever of the two limits is larger.
    localparam int CMAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          chrdy_q, chrdy_d;
    logic          busy_q, busy_d;
    logic [11:0]   addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic          bb1_q, bb1_d;
    logic          cx1_q, cx1_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   buf_q, buf_d;
    logic [7:0]    lo_q, lo_d;
    logic          is_rd_q, is_rd_d;
    logic [CW-1:0] elapsed;

    // Elapsed count includes the clock that ends at the current edge.
    assign elapsed = cnt_q + CW'(1);

    // State and register bank; reset releases the strobe and the bus drive at once.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_byte_q <= 8'h00;
            chrdy_q   <= 1'b1;
            busy_q    <= 1'b0;
            addr_q    <= 12'h000;
            dout_q    <= 16'h0000;
            bb1_q     <= 1'b1;
            cx1_q     <= 1'b1;
            tmo_q     <= 1'b0;
            buf_q     <= 16'h0000;
            lo_q      <= 8'h00;
            is_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_byte_q <= rd_byte_d;
            chrdy_q   <= chrdy_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            bb1_q     <= bb1_d;
            cx1_q     <= cx1_d;
            tmo_q     <= tmo_d;
            buf_q     <= buf_d;
            lo_q      <= lo_d;
            is_rd_q   <= is_rd_d;
        end
    end

    // Next-state logic: register accesses are taken only when idle, and a
    // write wins over a read that arrives in the same clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_byte_d = rd_byte_q;
        chrdy_d   = chrdy_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        bb1_d     = bb1_q;
        cx1_d     = cx1_q;
        tmo_d     = tmo_q;
        buf_d     = buf_q;
        lo_d      = lo_q;
        is_rd_d   = is_rd_q;

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    case (reg_sel)
                        3'd0: lo_d = wr_byte;
                        3'd1: begin
                            dout_d  = {wr_byte, lo_q};
                            is_rd_d = 1'b0;
                            bb1_d   = 1'b0;
                            chrdy_d = 1'b0;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_SETUP;
                        end
                        3'd2: addr_d[7:0]  = wr_byte;
                        3'd3: addr_d[11:8] = wr_byte[3:0];
                        default: ;
                    endcase
                end else if (rd_req) begin
                    case (reg_sel)
                        3'd0: begin
                            is_rd_d = 1'b1;
                            chrdy_d = 1'b0;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_SETUP;
                        end
                        3'd1: rd_byte_d = buf_q[15:8];
                        3'd2: rd_byte_d = addr_q[7:0];
                        3'd3: rd_byte_d = {4'b0000, addr_q[11:8]};
                        3'd4: begin
                            rd_byte_d = {6'b000000, tmo_q, busy_q};
                            tmo_d     = 1'b0;
                        end
                        default: rd_byte_d = 8'h00;
                    endcase
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    cx1_d   = 1'b0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = elapsed;
                end
            end
            S_STROBE: begin
                cnt_d = elapsed;
                // A valid response takes priority over a timeout that
                // expires in the same clock.
                if (elapsed >= CW'(STROBE_CYCLES) && !cb_prr) begin
                    cx1_d   = 1'b1;
                    state_d = S_HOLD;
                    if (is_rd_q) buf_d = cb_data_in;
                end else if (elapsed == CW'(TIMEOUT_CYCLES)) begin
                    cx1_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_HOLD;
                    if (is_rd_q) buf_d = 16'h0000;
                end
            end
            S_HOLD: begin
                bb1_d   = 1'b1;
                chrdy_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (is_rd_q) rd_byte_d = buf_q[7:0];
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_byte     = rd_byte_q;
    assign isa_chrdy   = chrdy_q;
    assign busy        = busy_q;
    assign cb_addr     = addr_q;
    assign cb_data_out = dout_q;
    assign cb_b_b1     = bb1_q;
    assign cb_cx1      = cx1_q;

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Self-checking bench for camac_cycle_sequencer: directed steps followed by
// randomized accesses, checked against a register/cycle-level model.
module tb_camac_cycle_sequencer;

    localparam int SETUP   = 2;
    localparam int STROBE  = 4;
    localparam int TIMEOUT = 64;

    logic        isa_clk = 1'b0;
    logic        isa_reset = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [7:0]  wr_byte = 8'h00;
    logic [7:0]  rd_byte;
    logic        isa_chrdy;
    logic        busy;
    logic [11:0] cb_addr;
    logic [15:0] cb_data_out;
    logic [15:0] cb_data_in = 16'h0000;
    logic        cb_b_b1;
    logic        cb_cx1;
    logic        cb_prr = 1'b1;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [11:0] m_addr = '0;
    logic [7:0]  m_lo   = '0;
    logic [15:0] m_buf  = '0;
    logic        m_to   = 1'b0;
    logic [7:0]  m_rd   = '0;
    logic [15:0] m_dout = '0;

    camac_cycle_sequencer #(
        .SETUP_CYCLES  (SETUP),
        .STROBE_CYCLES (STROBE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .isa_clk    (isa_clk),
        .isa_reset  (isa_reset),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .reg_sel    (reg_sel),
        .wr_byte    (wr_byte),
        .rd_byte    (rd_byte),
        .isa_chrdy  (isa_chrdy),
        .busy       (busy),
        .cb_addr    (cb_addr),
        .cb_data_out(cb_data_out),
        .cb_data_in (cb_data_in),
        .cb_b_b1    (cb_b_b1),
        .cb_cx1     (cb_cx1),
        .cb_prr     (cb_prr)
    );

    always #5 isa_clk = ~isa_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_lo = '0; m_buf = '0; m_to = 1'b0; m_rd = '0; m_dout = '0;
    endtask

    // Register write (optionally with a simultaneous read that must be dropped).
    task automatic reg_write(input logic [2:0] sel, input logic [7:0] b, input bit both);
        @(negedge isa_clk);
        wr_req = 1'b1; rd_req = both; reg_sel = sel; wr_byte = b;
        @(negedge isa_clk);
        wr_req = 1'b0; rd_req = 1'b0;
        case (sel)
            3'd0: m_lo = b;
            3'd2: m_addr[7:0] = b;
            3'd3: m_addr[11:8] = b[3:0];
            default: ;
        endcase
        chk("wr_chrdy", isa_chrdy, 1'b1);
        chk("wr_addr", cb_addr, m_addr);
        chk("wr_rdbyte", rd_byte, m_rd);
    endtask

    // Register read that must not start a bus cycle.
    task automatic reg_read(input logic [2:0] sel);
        @(negedge isa_clk);
        rd_req = 1'b1; reg_sel = sel;
        @(negedge isa_clk);
        rd_req = 1'b0;
        case (sel)
            3'd1: m_rd = m_buf[15:8];
            3'd2: m_rd = m_addr[7:0];
            3'd3: m_rd = {4'h0, m_addr[11:8]};
            3'd4: begin m_rd = {6'b0, m_to, 1'b0}; m_to = 1'b0; end
            default: m_rd = 8'h00;
        endcase
        chk($sformatf("rd_sel%0d", sel), rd_byte, m_rd);
        chk("rd_chrdy", isa_chrdy, 1'b1);
        chk("rd_cx1", cb_cx1, 1'b1);
    endtask

    // Full CAMAC cycle. d = strobe clock at which the module answers (0 = already
    // answering, > TIMEOUT = never). inject pulses a write request mid-cycle.
    task automatic camac_cycle(input bit is_wr, input int d, input bit both, input bit inject);
        logic [7:0]  b;
        logic [15:0] din;
        int n_chrdy, n_cx, n_bb, n_busy, low, tot;
        bit done, tmo;
        b = 8'($urandom);
        din = 16'($urandom);
        cb_data_in = din;
        cb_prr = (d == 0) ? 1'b0 : 1'b1;
        @(negedge isa_clk);
        if (is_wr) begin wr_req = 1'b1; rd_req = both; reg_sel = 3'd1; wr_byte = b; end
        else begin rd_req = 1'b1; reg_sel = 3'd0; end
        n_chrdy = 0; n_cx = 0; n_bb = 0; n_busy = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge isa_clk);
            wr_req = 1'b0; rd_req = 1'b0;
            if (inject && i == 2) begin
                wr_req = 1'b1; reg_sel = 3'd2; wr_byte = ~m_addr[7:0];
            end
            if (isa_chrdy) done = 1'b1;
            else begin
                n_chrdy++;
                if (!cb_cx1) n_cx++;
                if (!cb_b_b1) n_bb++;
                if (busy) n_busy++;
            end
            if (n_cx >= d) cb_prr = 1'b0;
        end
        wr_req = 1'b0;
        tmo = (d > TIMEOUT);
        low = tmo ? TIMEOUT : ((d > STROBE) ? d : STROBE);
        tot = SETUP + low + 1;
        if (is_wr) m_dout = {b, m_lo};
        else begin
            m_buf = tmo ? 16'h0000 : din;
            m_rd = m_buf[7:0];
        end
        if (tmo) m_to = 1'b1;
        chk("cyc_done", done, 1'b1);
        chk("cyc_chrdy_len", n_chrdy, tot);
        chk("cyc_busy_len", n_busy, tot);
        chk("cyc_cx1_len", n_cx, low);
        chk("cyc_bb1_len", n_bb, is_wr ? tot : 0);
        chk("cyc_rdbyte", rd_byte, m_rd);
        chk("cyc_dout", cb_data_out, m_dout);
        chk("cyc_addr", cb_addr, m_addr);
        chk("idle_cx1", cb_cx1, 1'b1);
        chk("idle_bb1", cb_b_b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        // Reset held: read requests must not start anything.
        isa_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge isa_clk);
            rd_req = 1'b1; reg_sel = 3'd0;
            #1;
            chk("rst_bb1", cb_b_b1, 1'b1);
            chk("rst_cx1", cb_cx1, 1'b1);
            chk("rst_chrdy", isa_chrdy, 1'b1);
            chk("rst_rdbyte", rd_byte, 8'h00);
        end
        @(negedge isa_clk);
        rd_req = 1'b0;
        isa_reset = 1'b1;
        repeat (3) @(negedge isa_clk);
        chk("post_rst_chrdy", isa_chrdy, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_addr", cb_addr, 12'h000);
        chk("post_rst_dout", cb_data_out, 16'h0000);

        // Write cycle with an immediate response.
        reg_write(3'd2, 8'h34, 1'b0);
        reg_write(3'd3, 8'h01, 1'b0);
        reg_write(3'd0, 8'hCD, 1'b0);
        chk("addr_134", cb_addr, 12'h134);
        camac_cycle(1'b1, 0, 1'b0, 1'b0);
        // The random byte from the cycle task replaced AB; check the low half.
        chk("dout_lo", cb_data_out[7:0], 8'hCD);

        // Read cycle, then high byte from the buffer.
        camac_cycle(1'b0, 0, 1'b0, 1'b0);
        reg_read(3'd1);
        reg_read(3'd2);
        reg_read(3'd3);

        // Slow module answers 10 clocks into the strobe.
        camac_cycle(1'b0, 10, 1'b0, 1'b0);
        reg_read(3'd4);

        // Timeout on a read, then status read twice.
        camac_cycle(1'b0, 1000, 1'b0, 1'b0);
        chk("tmo_rdbyte", rd_byte, 8'h00);
        reg_read(3'd4);
        chk("status_tmo", rd_byte, 8'h02);
        reg_read(3'd4);
        chk("status_clr", rd_byte, 8'h00);

        // Simultaneous read+write gives a single write; write during busy is ignored.
        camac_cycle(1'b1, 0, 1'b1, 1'b0);
        camac_cycle(1'b1, 3, 1'b0, 1'b1);
        camac_cycle(1'b0, 6, 1'b0, 1'b1);
        reg_write(3'd0, 8'h5E, 1'b1);

        // Undefined selects.
        reg_write(3'd5, 8'hFF, 1'b0);
        reg_read(3'd6);
        reg_read(3'd7);

        // Reset in the middle of a write strobe.
        cb_prr = 1'b1;
        @(negedge isa_clk);
        wr_req = 1'b1; reg_sel = 3'd1; wr_byte = 8'h5A;
        @(negedge isa_clk);
        wr_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge isa_clk);
            if (!cb_cx1) seen = 1;
        end
        chk("abort_strobe_seen", seen, 1);
        @(negedge isa_clk);
        isa_reset = 1'b0;
        #1;
        chk("abort_cx1", cb_cx1, 1'b1);
        chk("abort_bb1", cb_b_b1, 1'b1);
        chk("abort_chrdy", isa_chrdy, 1'b1);
        chk("abort_busy", busy, 1'b0);
        @(negedge isa_clk);
        isa_reset = 1'b1;
        model_reset();
        reg_read(3'd2);

        // Randomized mix of accesses.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    logic [2:0] s;
                    s = 3'($urandom_range(0, 5));
                    if (s == 3'd1) s = 3'd3;
                    reg_write(s, 8'($urandom), 1'b0);
                end
                1: begin
                    logic [2:0] s;
                    s = 3'($urandom_range(1, 7));
                    reg_read(s);
                end
                2: camac_cycle(1'b1, ($urandom_range(0, 7) == 0) ? 90 : int'($urandom_range(0, 12)),
                               1'($urandom), 1'($urandom));
                3: camac_cycle(1'b0, ($urandom_range(0, 7) == 0) ? 90 : int'($urandom_range(0, 12)),
                               1'b0, 1'($urandom));
                default: reg_write(3'd0, 8'($urandom), 1'b1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/camac_cycle_sequencer.md
Name: camac_cycle_sequencer

Overview:
Sits between the ISA register decoder and the CAMAC backplane pins inside the SM2201 interface board. It converts 8-bit ISA register accesses into single 16-bit CAMAC read/write cycles, holds isa_chrdy low while a cycle runs, and keeps the CAMAC data bus passive (cb_b_b1=1, cx1 inactive) whenever idle. All logic runs on the ISA clock.

Parameters:
SETUP_CYCLES, 2, clocks of address/data setup before the strobe (min 1)
STROBE_CYCLES, 4, minimum clocks cb_cx1 is held low (min 1)
TIMEOUT_CYCLES, 64, maximum clocks in strobe waiting for cb_prr before aborting (> STROBE_CYCLES)

Ports:
isa_clk  in  1  ISA bus clock; only clock
isa_reset  in  1  asynchronous, active-low reset
rd_req  in  1  one-clock read pulse from decoder
wr_req  in  1  one-clock write pulse from decoder
reg_sel  in  3  0=data lo, 1=data hi, 2=addr lo, 3=addr hi, 4=status
wr_byte  in  8  ISA write data
rd_byte  out  8  registered ISA read data
isa_chrdy  out  1  0 = insert ISA wait states
busy  out  1  1 while a CAMAC cycle is in progress
cb_addr  out  12  CAMAC N/A/F address
cb_data_out  out  16  CAMAC write data
cb_data_in  in  16  CAMAC read data
cb_b_b1  out  1  bus direction: 1 = board passive/receive, 0 = board drives cb_data
cb_cx1  out  1  CAMAC cycle strobe, active-low
cb_prr  in  1  module response/ready, active-low

Behaviour:
- Reset (async, isa_reset=0): state IDLE; rd_byte=0, isa_chrdy=1, busy=0, cb_addr=0, cb_data_out=0, cb_b_b1=1, cb_cx1=1, timeout flag=0, read buffer=0, data-lo latch=0. Applies mid-cycle: the strobe and bus drive are released immediately.
- Registers, no bus cycle: write sel2 -> cb_addr[7:0]; write sel3 -> cb_addr[11:8] = wr_byte[3:0]; write sel0 -> data-lo latch. Read sel2/3 -> current address (hi: {4'b0, cb_addr[11:8]}). Read sel1 -> read-buffer[15:8]. Read sel4 -> {6'b0, timeout, busy}, and the same read clears timeout.
- Write sel1 starts a CAMAC WRITE: cb_data_out = {wr_byte, data-lo latch}. Read sel0 starts a CAMAC READ; rd_byte is updated with buffer[7:0] in DONE.
- rd_byte updates on the clock after rd_req for non-cycle reads.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- On the start edge: isa_chrdy=0 and busy=1 (registered, same edge). cb_b_b1=0 for a write, stays 1 for a read.
- SETUP: lasts SETUP_CYCLES clocks; cb_cx1=1.
- STROBE: cb_cx1=0. Exit when at least STROBE_CYCLES clocks have elapsed AND cb_prr=0, or when TIMEOUT_CYCLES clocks have elapsed.
  - Normal exit on a read: buffer <= cb_data_in, sampled on the exiting edge.
  - Timeout exit: timeout=1; a read loads buffer=16'h0000.
- HOLD: 1 clock; cb_cx1=1, direction unchanged.
- Leaving HOLD: cb_b_b1=1, isa_chrdy=1, busy=0; a read also sets rd_byte=buffer[7:0].
- Total nominal latency with prr already low: SETUP_CYCLES+STROBE_CYCLES+1 clocks (default 7).
- rd_req and wr_req in the same clock: write handled, read dropped.
- Any request while busy: ignored; no state, latch or register change.
- Undefined reg_sel (5-7): writes ignored, reads return 8'h00.
- Idle invariant: cb_b_b1=1 and cb_cx1=1 at all times outside SETUP/STROBE/HOLD (bus passivity).

Test Plan:
- Reset: hold isa_reset=0, pulse rd_req sel0 -> cb_b_b1=1, cb_cx1=1, isa_chrdy=1, rd_byte=0 throughout; no cycle after release.
- Write: sel2 8'h34, sel3 8'h01, sel0 8'hCD, sel1 8'hAB, cb_prr tied 0 -> cb_addr=12'h134, cb_data_out=16'hABCD, cb_b_b1=0 for 7 clocks, cb_cx1 low exactly 4 clocks, isa_chrdy low 7 clocks.
- Read: cb_data_in=16'h1234, cb_prr=0, rd_req sel0 -> rd_byte=8'h34 at cycle end; subsequent rd_req sel1 -> rd_byte=8'h12 with no cx1 pulse; cb_b_b1 stays 1.
- Slow module: cb_prr falls 10 clocks into STROBE -> cx1 low 10 clocks, read completes normally, timeout=0.
- Timeout: cb_prr held 1, read sel0 -> cx1 low 64 clocks, rd_byte=8'h00; status read = 8'h02; second status read = 8'h00.
- Abort and collisions: isa_reset=0 mid-STROBE -> cx1=1, b_b1=1, chrdy=1 immediately. rd_req+wr_req together -> single write cycle. wr_req during busy -> no effect.
